// File: rtl/mem_load_sequencer.sv
// Load-path sequencer: single-beat bus read, lane select onto byte/half/word outputs.
// Optional misaligned-access trap enabled by defining LOAD_MISALIGN_TRAP_EN.
module mem_load_sequencer #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    output logic              bus_rd_en,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic [7:0]        ByteOut,
    output logic [15:0]       HalfOut,
    output logic [31:0]       WordOut,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size_q;
    logic [1:0]       offs_q;
    logic             req_illegal;

    always_comb begin
        req_illegal = (req_size == 2'b11);
`ifdef LOAD_MISALIGN_TRAP_EN
        if (req_size == 2'b01 && req_addr[0])
            req_illegal = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            req_illegal = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            size_q    <= '0;
            offs_q    <= '0;
            req_ready <= 1'b1;
            bus_rd_en <= 1'b0;
            bus_addr  <= '0;
            ByteOut   <= '0;
            HalfOut   <= '0;
            WordOut   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        size_q    <= req_size;
                        offs_q    <= req_addr[1:0];
                        cnt       <= '0;
                        if (req_illegal) begin
                            // Error-only path: respond next cycle, never touch the bus
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            ByteOut   <= '0;
                            HalfOut   <= '0;
                            WordOut   <= '0;
                        end else begin
                            state     <= WAIT;
                            bus_rd_en <= 1'b1;
                            bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                WAIT: begin
                    // Ack is checked first so it wins over a simultaneous timeout
                    if (bus_ack) begin
                        state     <= RESP;
                        bus_rd_en <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        case (size_q)
                            2'b00: begin
                                case (offs_q)
                                    2'd0:    ByteOut <= bus_rdata[7:0];
                                    2'd1:    ByteOut <= bus_rdata[15:8];
                                    2'd2:    ByteOut <= bus_rdata[23:16];
                                    default: ByteOut <= bus_rdata[31:24];
                                endcase
                            end
                            2'b01:   HalfOut <= offs_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
                            2'b10:   WordOut <= bus_rdata;
                            default: ;
                        endcase
                    end else if (cnt == CNT_LAST) begin
                        state     <= RESP;
                        bus_rd_en <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        ByteOut   <= '0;
                        HalfOut   <= '0;
                        WordOut   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Directed-vector bench for mem_load_sequencer; cycle numbers count from the accept edge.
// Honours LOAD_MISALIGN_TRAP_EN the same way as the design.
module tb_mem_load_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        bus_rd_en;
    logic [31:0] bus_addr;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [7:0]  ByteOut;
    logic [15:0] HalfOut;
    logic [31:0] WordOut;
    logic        rsp_valid;
    logic        rsp_err;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_load_sequencer #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .bus_rd_en (bus_rd_en),
        .bus_addr  (bus_addr),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .ByteOut   (ByteOut),
        .HalfOut   (HalfOut),
        .WordOut   (WordOut),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [7:0] b, input logic [15:0] h,
                              input logic [31:0] w);
        check({tag, ":byte"}, 32'(ByteOut), 32'(b));
        check({tag, ":half"}, 32'(HalfOut), 32'(h));
        check({tag, ":word"}, WordOut, w);
    endtask

    // One request; ack_at is the cycle bus_ack is driven (0 = never), exp_rd the
    // expected number of cycles with bus_rd_en high.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input int ack_at, input logic [31:0] rdata, input int exp_rsp,
                            input logic exp_err, input int exp_rd);
        int rd_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        req_size  = size;
        check({tag, ":ready_in"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= exp_rsp + 2; cyc++) begin
            @(negedge clk);
            bus_ack   = (cyc == ack_at);
            bus_rdata = rdata;
            if (bus_rd_en) rd_cnt++;
            if (cyc == 1 && exp_rd > 0)
                check({tag, ":bus_addr"}, bus_addr, {addr[31:2], 2'b00});
            check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'(cyc == exp_rsp));
            if (cyc == exp_rsp)
                check({tag, ":rsp_err"}, 32'(rsp_err), 32'(exp_err));
            if (cyc == exp_rsp + 1)
                check({tag, ":ready_back"}, 32'(req_ready), 32'd1);
            if (cyc == exp_rsp + 2)
                check({tag, ":idle_busy"}, 32'(busy), 32'd0);
        end
        bus_ack = 1'b0;
        check({tag, ":rd_cycles"}, 32'(rd_cnt), 32'(exp_rd));
    endtask

    initial begin
        int pulses;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst:ready", 32'(req_ready), 32'd1);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:rd_en", 32'(bus_rd_en), 32'd0);
        check("rst:bus_addr", bus_addr, 32'd0);
        check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
        check_data("rst", 8'h00, 16'h0000, 32'h0);
        rst_n = 1'b1;

        run_load("byte3", 32'h1003, 2'b00, 1, 32'hA1B2C3D4, 2, 1'b0, 1);
        check_data("byte3", 8'hA1, 16'h0000, 32'h0);
        run_load("byte1", 32'h1001, 2'b00, 1, 32'hA1B2C3D4, 2, 1'b0, 1);
        check_data("byte1", 8'hC3, 16'h0000, 32'h0);
        run_load("half2", 32'h1002, 2'b01, 1, 32'hA1B2C3D4, 2, 1'b0, 1);
        check_data("half2", 8'hC3, 16'hA1B2, 32'h0);
        run_load("word_dly", 32'h1000, 2'b10, 4, 32'hA1B2C3D4, 5, 1'b0, 4);
        check_data("word_dly", 8'hC3, 16'hA1B2, 32'hA1B2C3D4);

        // Ack in cycle 17 arrives after the timeout response and must be ignored
        run_load("timeout", 32'h2000, 2'b10, 17, 32'hFFFFFFFF, 16, 1'b1, 15);
        check_data("timeout", 8'h00, 16'h0000, 32'h0);

        run_load("race", 32'h3000, 2'b10, 15, 32'hDEADBEEF, 16, 1'b0, 15);
        check_data("race", 8'h00, 16'h0000, 32'hDEADBEEF);

        run_load("rsvd", 32'h3000, 2'b11, 0, 32'h12345678, 1, 1'b1, 0);
        check_data("rsvd", 8'h00, 16'h0000, 32'h0);

`ifdef LOAD_MISALIGN_TRAP_EN
        run_load("mis_half", 32'h1001, 2'b01, 0, 32'h11223344, 1, 1'b1, 0);
        check_data("mis_half", 8'h00, 16'h0000, 32'h0);
`else
        run_load("mis_half", 32'h1001, 2'b01, 1, 32'h11223344, 2, 1'b0, 1);
        check_data("mis_half", 8'h00, 16'h3344, 32'h0);
`endif

        run_load("pre_rst", 32'h4000, 2'b10, 1, 32'h55667788, 2, 1'b0, 1);

        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h4004;
        req_size  = 2'b00;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid:rd_en_c1", 32'(bus_rd_en), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid:rd_en", 32'(bus_rd_en), 32'd0);
        check("mid:busy", 32'(busy), 32'd0);
        check("mid:ready", 32'(req_ready), 32'd1);
        check_data("mid", 8'h00, 16'h0000, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("mid:no_rsp", 32'(pulses), 32'd0);
        check("mid:idle_rd_en", 32'(bus_rd_en), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
